pack_wr_sched: RTL and testbench

- Write-side scheduler for the shared 32-bit activation SRAM write port.
- Accepts packed pixel words from the pixel packer (level-valid, acked by a save_done pulse) and host/loader writes (valid/ack).
- Arbitrates between the two sources round-robin and generates sequential word addresses for the packer stream.
- Counts words per frame and pulses frame_done after the last word of a frame is written.

---
 rtl/npu_pkg.sv | 17 +
 rtl/pack_wr_sched_rr_arb2.sv | 39 +++
 rtl/pack_wr_sched.sv | 147 ++++++++++++++
 tb/tb_pack_wr_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// npu_pkg: shared frame geometry and state/source types for the NPU activation write path.
package npu_pkg;

   localparam int NUM_PIX      = 182;
   localparam int PIX_PER_WORD = 4;
   localparam int WORD_IDX_W   = 6;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   localparam int WORDS = ceil_div(NUM_PIX, PIX_PER_WORD);

   typedef enum logic [1:0] {IDLE, WRITE, ACK} wr_state_t;
   typedef enum logic       {SRC_PACK, SRC_HOST} wr_src_t;

endpackage

// File: rtl/pack_wr_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; grant is combinational, the favoured-source pointer is registered.
module rr_arb2
   import npu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   input  wr_src_t    upd_src,
   input  logic       clr,
   output logic [1:0] grant
);

   wr_src_t ptr;
   wr_src_t eff_ptr;

   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      grant   = 2'b00;
      eff_ptr = clr ? SRC_PACK : ptr;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (eff_ptr == SRC_PACK) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // After a completed write the pointer favours whichever source was not just served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= SRC_PACK;
      else if (clr)
         ptr <= SRC_PACK;
      else if (update)
         ptr <= (upd_src == SRC_PACK) ? SRC_HOST : SRC_PACK;
   end

endmodule

// File: rtl/pack_wr_sched.sv
// pack_wr_sched: packer/host write scheduler for the shared activation SRAM port.
// Optional PACK_WR_SCHED_PERF_EN adds a saturating SRAM stall counter output.
module pack_wr_sched
   import npu_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int NUM_PIX      = npu_pkg::NUM_PIX,
   parameter int PIX_PER_WORD = npu_pkg::PIX_PER_WORD,
   parameter int BASE_ADDR    = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_clr,
   input  logic              pack_valid,
   input  logic [DATA_W-1:0] pack_data,
   output logic              save_done,
   input  logic              host_valid,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_data,
   output logic              host_ack,
   output logic              sram_cs,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic              sram_ready,
   output logic              frame_done,
   output logic [5:0]        word_idx
`ifdef PACK_WR_SCHED_PERF_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   localparam logic [5:0]        LAST_IDX = 6'(ceil_div(NUM_PIX, PIX_PER_WORD) - 1);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

   wr_state_t  state;
   wr_src_t    src;
   logic       clr_pend;
   logic [5:0] word_cnt;
   logic [1:0] req;
   logic [1:0] grant;
   logic       wr_done;
   logic       arb_clr;

   // A source is ignored in its own ack cycle; it drops valid on the following edge.
   assign req      = {host_valid & ~host_ack, pack_valid & ~save_done};
   assign wr_done  = (state == WRITE) & sram_cs & sram_ready;
   assign arb_clr  = frame_clr | (clr_pend & wr_done);
   assign word_idx = word_cnt;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .update  (wr_done),
      .upd_src (src),
      .clr     (arb_clr),
      .grant   (grant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         src        <= SRC_PACK;
         clr_pend   <= 1'b0;
         word_cnt   <= '0;
         sram_cs    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         save_done  <= 1'b0;
         host_ack   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         save_done  <= 1'b0;
         host_ack   <= 1'b0;
         frame_done <= 1'b0;
         if (frame_clr)
            word_cnt <= '0;

         case (state)
            IDLE: begin
               clr_pend <= 1'b0;
               if (grant[0]) begin
                  src        <= SRC_PACK;
                  sram_addr  <= frame_clr ? BASE : BASE + ADDR_W'(word_cnt);
                  sram_wdata <= pack_data;
                  sram_cs    <= 1'b1;
                  state      <= WRITE;
               end else if (grant[1]) begin
                  src        <= SRC_HOST;
                  sram_addr  <= host_addr;
                  sram_wdata <= host_data;
                  sram_cs    <= 1'b1;
                  state      <= WRITE;
               end
            end

            WRITE: begin
               if (wr_done) begin
                  sram_cs  <= 1'b0;
                  state    <= ACK;
                  clr_pend <= 1'b0;
                  if (src == SRC_PACK) begin
                     save_done <= 1'b1;
                     // A clear seen during the write wins over the increment and the frame end.
                     if (frame_clr || clr_pend) begin
                        word_cnt <= '0;
                     end else if (word_cnt == LAST_IDX) begin
                        word_cnt   <= '0;
                        frame_done <= 1'b1;
                     end else begin
                        word_cnt <= word_cnt + 6'd1;
                     end
                  end else begin
                     host_ack <= 1'b1;
                  end
               end else if (frame_clr) begin
                  clr_pend <= 1'b1;
               end
            end

            ACK: begin
               state <= IDLE;
            end

            default: begin
               state   <= IDLE;
               sram_cs <= 1'b0;
            end
         endcase
      end
   end

`ifdef PACK_WR_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (frame_clr)
         stall_cnt <= '0;
      else if (sram_cs && !sram_ready && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_pack_wr_sched.sv
// tb_pack_wr_sched: directed self-checking bench for pack_wr_sched (optionally with PACK_WR_SCHED_PERF_EN).
module tb_pack_wr_sched;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic        frame_clr  = 1'b0;
   logic        pack_valid = 1'b0;
   logic [31:0] pack_data  = '0;
   logic        host_valid = 1'b0;
   logic [9:0]  host_addr  = '0;
   logic [31:0] host_data  = '0;
   logic        sram_ready = 1'b1;
   logic        save_done;
   logic        host_ack;
   logic        sram_cs;
   logic [9:0]  sram_addr;
   logic [31:0] sram_wdata;
   logic        frame_done;
   logic [5:0]  word_idx;
`ifdef PACK_WR_SCHED_PERF_EN
   logic [15:0] stall_cnt;
`endif

   pack_wr_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_clr  (frame_clr),
      .pack_valid (pack_valid),
      .pack_data  (pack_data),
      .save_done  (save_done),
      .host_valid (host_valid),
      .host_addr  (host_addr),
      .host_data  (host_data),
      .host_ack   (host_ack),
      .sram_cs    (sram_cs),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_ready (sram_ready),
      .frame_done (frame_done),
      .word_idx   (word_idx)
`ifdef PACK_WR_SCHED_PERF_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Write/ack log, sampled on the falling edge.
   logic [9:0]  wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          ack_q[$];
   int          pack_acks = 0;
   int          fd_cnt    = 0;
   int          fd_at     = -1;

   always @(negedge clk) begin
      if (sram_cs && sram_ready) begin
         wr_addr_q.push_back(sram_addr);
         wr_data_q.push_back(sram_wdata);
      end
      if (save_done) begin
         pack_acks++;
         ack_q.push_back(0);
      end
      if (host_ack)
         ack_q.push_back(1);
      if (frame_done) begin
         fd_cnt++;
         fd_at = pack_acks;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pack_write(input logic [31:0] d, output int lat);
      @(posedge clk); #1;
      pack_valid = 1'b1;
      pack_data  = d;
      lat        = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (save_done) break;
      end
      check("pack_ack_seen", 32'(save_done), 32'd1);
   endtask

   task automatic pack_idle();
      @(posedge clk); #1;
      pack_valid = 1'b0;
   endtask

   task automatic host_write(input logic [9:0] a, input logic [31:0] d, output int lat);
      @(posedge clk); #1;
      host_valid = 1'b1;
      host_addr  = a;
      host_data  = d;
      lat        = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (host_ack) break;
      end
      check("host_ack_seen", 32'(host_ack), 32'd1);
   endtask

   task automatic host_idle();
      @(posedge clk); #1;
      host_valid = 1'b0;
   endtask

   task automatic clr_frame();
      @(posedge clk); #1;
      frame_clr = 1'b1;
      @(posedge clk); #1;
      frame_clr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int lh;
      int n0;
      int acks0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_cs", 32'(sram_cs), 32'd0);
      check("rst_save_done", 32'(save_done), 32'd0);
      check("rst_host_ack", 32'(host_ack), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_word_idx", 32'(word_idx), 32'd0);
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_wdata", sram_wdata, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Simultaneous requests: packer first after reset, then alternation
      for (int p = 0; p < 2; p++) begin
         ack_q.delete();
         n0 = wr_addr_q.size();
         fork
            begin pack_write(32'h1111_0000 + 32'(p), lat); pack_idle(); end
            begin host_write(10'h200, 32'hCAFE_0000 + 32'(p), lh); host_idle(); end
         join
         check("rr_ack_count", 32'(ack_q.size()), 32'd2);
         check("rr_first_pack", 32'(ack_q[0]), 32'd0);
         check("rr_second_host", 32'(ack_q[1]), 32'd1);
         check("rr_pack_lat", 32'(lat), 32'd3);
         check("rr_host_lat", 32'(lh), 32'd6);
         check("rr_pack_addr", 32'(wr_addr_q[n0]), 32'(p));
         check("rr_pack_data", wr_data_q[n0], 32'h1111_0000 + 32'(p));
         check("rr_host_addr", 32'(wr_addr_q[n0 + 1]), 32'h200);
         check("rr_host_data", wr_data_q[n0 + 1], 32'hCAFE_0000 + 32'(p));
         check("rr_word_idx", 32'(word_idx), 32'(p + 1));
      end

      // A lone packer write moves the pointer to the host for the next tie
      pack_write(32'h2222_0002, lat);
      pack_idle();
      check("solo_word_idx", 32'(word_idx), 32'd3);
      ack_q.delete();
      n0 = wr_addr_q.size();
      fork
         begin pack_write(32'h3333_0003, lat); pack_idle(); end
         begin host_write(10'h201, 32'hCAFE_0009, lh); host_idle(); end
      join
      check("rr3_first_host", 32'(ack_q[0]), 32'd1);
      check("rr3_second_pack", 32'(ack_q[1]), 32'd0);
      check("rr3_host_lat", 32'(lh), 32'd3);
      check("rr3_pack_lat", 32'(lat), 32'd6);
      check("rr3_host_addr", 32'(wr_addr_q[n0]), 32'h201);
      check("rr3_pack_addr", 32'(wr_addr_q[n0 + 1]), 32'd3);
      check("rr3_word_idx", 32'(word_idx), 32'd4);

      // Full frame of 46 words, valid held back-to-back
      clr_frame();
      check("clr_word_idx", 32'(word_idx), 32'd0);
      fd_cnt = 0;
      acks0  = pack_acks;
      n0     = wr_addr_q.size();
      for (int i = 0; i < 46; i++) begin
         pack_write({16'(i), 16'hA5A5}, lat);
         check("frame_lat", 32'(lat), 32'd3);
      end
      pack_idle();
      repeat (2) @(negedge clk);
      check("frame_write_count", 32'(wr_addr_q.size() - n0), 32'd46);
      for (int i = 0; i < 46; i++) begin
         check("frame_addr", 32'(wr_addr_q[n0 + i]), 32'(i));
         check("frame_data", wr_data_q[n0 + i], {16'(i), 16'hA5A5});
      end
      check("frame_done_count", 32'(fd_cnt), 32'd1);
      check("frame_done_at_word", 32'(fd_at - acks0), 32'd46);
      check("frame_word_idx_wrap", 32'(word_idx), 32'd0);

      // SRAM stall of 5 cycles during a packer write
      clr_frame();
      n0 = wr_addr_q.size();
      fork
         begin pack_write(32'h5EED_0000, lat); pack_idle(); end
         begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            sram_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("stall_cs", 32'(sram_cs), 32'd1);
               check("stall_addr", 32'(sram_addr), 32'd0);
               check("stall_data", sram_wdata, 32'h5EED_0000);
               check("stall_no_ack", 32'(save_done), 32'd0);
            end
            @(posedge clk); #1;
            sram_ready = 1'b1;
         end
      join
      check("stall_lat", 32'(lat), 32'd8);
      check("stall_write_count", 32'(wr_addr_q.size() - n0), 32'd1);
`ifdef PACK_WR_SCHED_PERF_EN
      check("stall_cnt", 32'(stall_cnt), 32'd5);
`endif

      // frame_clr during the write of word 20
      clr_frame();
      fd_cnt = 0;
      for (int i = 0; i < 20; i++)
         pack_write({16'(i), 16'h0C0C}, lat);
      check("pre_clr_word_idx", 32'(word_idx), 32'd20);
      n0 = wr_addr_q.size();
      fork
         begin pack_write(32'h0014_0C0C, lat); pack_idle(); end
         begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            sram_ready = 1'b0;
            frame_clr  = 1'b1;
            @(posedge clk); #1;
            frame_clr  = 1'b0;
            @(posedge clk); #1;
            sram_ready = 1'b1;
         end
      join
      check("clr_inflight_addr", 32'(wr_addr_q[n0]), 32'd20);
      check("clr_inflight_data", wr_data_q[n0], 32'h0014_0C0C);
      check("clr_word_idx_after", 32'(word_idx), 32'd0);
      pack_write(32'h0000_0C0C, lat);
      pack_idle();
      check("clr_next_addr", 32'(wr_addr_q[n0 + 1]), 32'd0);
      check("clr_next_word_idx", 32'(word_idx), 32'd1);
      check("clr_no_frame_done", 32'(fd_cnt), 32'd0);

      // Reset asserted in WRITE
      acks0 = pack_acks;
      @(posedge clk); #1;
      pack_valid = 1'b1;
      pack_data  = 32'hDEAD_BEEF;
      sram_ready = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rstw_cs_before", 32'(sram_cs), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rstw_cs", 32'(sram_cs), 32'd0);
      check("rstw_save_done", 32'(save_done), 32'd0);
      check("rstw_host_ack", 32'(host_ack), 32'd0);
      check("rstw_word_idx", 32'(word_idx), 32'd0);
      pack_valid = 1'b0;
      sram_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n0 = wr_addr_q.size();
      pack_write(32'h0000_0001, lat);
      pack_idle();
      check("rstw_first_addr", 32'(wr_addr_q[n0]), 32'd0);
      check("rstw_ack_count", 32'(pack_acks - acks0), 32'd1);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
